cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 26 ++
 rtl/cache_line_ram.sv | 37 +++
 rtl/cache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared constants for the direct-mapped write-through cache controller:
// datapath widths, FSM state codes and the byte-merge helper.
package cache_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] ST_INIT   = 7'd0;
  localparam logic [STATE_W-1:0] ST_IDLE   = 7'd1;
  localparam logic [STATE_W-1:0] ST_LOOKUP = 7'd2;
  localparam logic [STATE_W-1:0] ST_FILL   = 7'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 7'd4;

  // Bytes whose mask bit is set come from newWord, the rest keep oldWord.
  function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldWord,
                                                   input logic [DATA_W-1:0] newWord,
                                                   input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] result;
    for (int b = 0; b < MASK_W; b++) begin
      result[8*b +: 8] = mask[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Line storage for the cache: valid, tag and data arrays with one
// combinational read port and one synchronous write port.
module cache_line_ram import cache_ctrl_pkg::*; #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 22
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [DATA_W-1:0]     o_rd_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic                  i_wr_valid,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]     i_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic                r_valid [LINES];
  logic [TAG_BITS-1:0] r_tag   [LINES];
  logic [DATA_W-1:0]   r_data  [LINES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_data[i_wr_idx]  <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller: one 32-bit
// word per line, valid-bit sweep after reset, single outstanding memory access.
module cache_ctrl import cache_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [MASK_W-1:0]     i_mask,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_busy,
  output logic                  w_init_done,
  output logic [STATE_W-1:0]    state,
  output logic                  c_oe,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MASK_W-1:0]     mem_wmask,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  logic [STATE_W-1:0]    r_state;
  logic [INDEX_BITS-1:0] r_sweep;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [MASK_W-1:0]     r_wmask;
  logic [DATA_W-1:0]     r_data;
  logic                  r_c_oe;
  logic                  r_init_done;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_line_valid;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic [DATA_W-1:0]     w_line_data;
  logic                  w_hit;
  logic                  w_ram_we;
  logic [INDEX_BITS-1:0] w_ram_idx;
  logic                  w_ram_valid;
  logic [DATA_W-1:0]     w_ram_data;

  assign w_idx = r_addr[INDEX_BITS+1:2];
  assign w_tag = r_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit = w_line_valid && (w_line_tag == w_tag);

  cache_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_line_ram (
    .clk        (clk),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_we       (w_ram_we),
    .i_wr_idx   (w_ram_idx),
    .i_wr_valid (w_ram_valid),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_ram_data)
  );

  // Line writes: invalidate during the sweep, allocate on fill, merge on write hit.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_idx   = w_idx;
    w_ram_valid = 1'b1;
    w_ram_data  = mem_rdata;
    case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_idx   = r_sweep;
        w_ram_valid = 1'b0;
      end
      ST_FILL:  w_ram_we = mem_ack;
      ST_WRITE: begin
        w_ram_we   = mem_ack && w_hit;
        w_ram_data = mergeBytes(w_line_data, r_wdata, r_wmask);
      end
      default: w_ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_data      <= '0;
      r_c_oe      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_c_oe <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_sweep == LAST_IDX) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_wr_en) begin
            r_addr  <= i_addr;
            r_wdata <= i_data;
            r_wmask <= i_mask;
            r_state <= ST_WRITE;
          end else if (i_rd_en) begin
            r_addr  <= i_addr;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_data  <= w_line_data;
            r_c_oe  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            r_data  <= mem_rdata;
            r_c_oe  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Memory handshake is a pure function of state so reset drops it on the next edge.
  assign mem_req     = (r_state == ST_FILL) || (r_state == ST_WRITE);
  assign mem_we      = (r_state == ST_WRITE);
  assign mem_addr    = r_addr & ~ADDR_WIDTH'(3);
  assign mem_wdata   = r_wdata;
  assign mem_wmask   = r_wmask;
  assign o_data      = r_data;
  assign c_oe        = r_c_oe;
  assign o_busy      = (r_state != ST_IDLE);
  assign w_init_done = r_init_done;
  assign state       = r_state;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random traffic
// compared against a line-table/memory-map reference model.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        i_rd_en, i_wr_en;
  logic [31:0] i_addr, i_data;
  logic [3:0]  i_mask;
  logic [31:0] o_data;
  logic        o_busy, w_init_done, c_oe;
  logic [6:0]  state;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  bit          mValid [256];
  logic [29:0] mLine  [256];
  logic [31:0] memWords [int unsigned];
  logic [31:0] expData;
  logic [31:0] bases [3];

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_WIDTH(32), .INDEX_BITS(8)) dut (
    .clk(clk), .rst_x(rst_x), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask), .o_data(o_data),
    .o_busy(o_busy), .w_init_done(w_init_done), .state(state), .c_oe(c_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Backing memory: untouched words hold an address-derived pattern.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    int unsigned key = a >> 2;
    if (memWords.exists(key)) return memWords[key];
    return (a & ~32'h3) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic memWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w = memRead(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    memWords[a >> 2] = w;
  endtask

  task automatic runInit();
    int bad = 0;
    rst_x = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstState", state, 0);
    checkOutput("rstBusy", o_busy, 1);
    checkOutput("rstDone", w_init_done, 0);
    checkOutput("rstOdata", o_data, 0);
    checkOutput("rstCoe", c_oe, 0);
    checkOutput("rstMemReq", mem_req, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWdata", {mem_wmask, mem_we, mem_wdata[26:0]}, 0);
    rst_x = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (o_busy !== 1'b1 || w_init_done !== 1'b0 || state !== 7'd0) bad++;
    end
    checkOutput("initBusyCycles", bad, 0);
    @(negedge clk);
    checkOutput("initDoneState", state, 1);
    checkOutput("initDone", w_init_done, 1);
    checkOutput("initNotBusy", o_busy, 0);
    for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
    expData = 32'h0;
  endtask

  // op: 0 = read, 1 = write, 2 = read and write together (write wins).
  task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m, input int lat, input bit spurAck);
    int  idx = int'(a[9:2]);
    bit  hit = mValid[idx] && (mLine[idx] == a[31:2]);
    bit  isWrite = (op != 0);
    @(negedge clk);
    checkOutput("coeIdle", c_oe, 0);
    checkOutput("busyIdle", o_busy, 0);
    i_addr  = a;
    i_data  = d;
    i_mask  = m;
    i_rd_en = (op != 1);
    i_wr_en = isWrite;
    mem_ack = spurAck;
    @(negedge clk);
    i_rd_en = 1'b0;
    i_wr_en = 1'b0;
    mem_ack = 1'b0;
    if (!isWrite) begin
      checkOutput("lookupState", state, 2);
      checkOutput("lookupBusy", o_busy, 1);
      @(negedge clk);
      if (!hit) begin
        checkOutput("fillState", state, 3);
        checkOutput("fillReq", mem_req, 1);
        checkOutput("fillWe", mem_we, 0);
        checkOutput("fillAddr", mem_addr, a & ~32'h3);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          checkOutput("fillHold", {state, mem_req}, {7'd3, 1'b1});
        end
        mem_ack   = 1'b1;
        mem_rdata = memRead(a);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        mValid[idx] = 1'b1;
        mLine[idx]  = a[31:2];
      end else begin
        checkOutput("hitNoReq", mem_req, 0);
      end
      expData = memRead(a);
      checkOutput("readBusy", o_busy, 0);
      checkOutput("readCoe", c_oe, 1);
      checkOutput("readData", o_data, expData);
    end else begin
      checkOutput("writeState", state, 4);
      checkOutput("writeReq", {mem_req, mem_we}, 2'b11);
      checkOutput("writeAddr", mem_addr, a & ~32'h3);
      checkOutput("writeData", mem_wdata, d);
      checkOutput("writeMask", mem_wmask, m);
      checkOutput("writeCoe", c_oe, 0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        checkOutput("writeHold", {state, mem_req, c_oe, mem_wdata}, {7'd4, 1'b1, 1'b0, d});
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      memWrite(a, d, m);
      checkOutput("writeDoneBusy", {o_busy, mem_req, c_oe}, 3'b000);
      checkOutput("writeKeepsOdata", o_data, expData);
    end
  endtask

  initial begin
    i_rd_en = 1'b0; i_wr_en = 1'b0; i_addr = '0; i_data = '0; i_mask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    bases[0] = 32'h0000_0000; bases[1] = 32'h0000_0400; bases[2] = 32'hFFFF_FC00;
    runInit();

    memWords[32'h100 >> 2] = 32'hDEADBEEF;
    applyStimulus(0, 32'h100, 0, 0, 3, 0);
    checkOutput("missValue", o_data, 32'hDEADBEEF);
    applyStimulus(0, 32'h100, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 32'h11223344, 4'b0011, 1, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0);
    checkOutput("mergeValue", o_data, 32'hDEAD3344);
    applyStimulus(0, 32'h500, 0, 0, 0, 0);
    applyStimulus(0, 32'h102, 0, 0, 2, 0);
    applyStimulus(2, 32'h200, 32'hCAFEF00D, 4'b1111, 0, 0);
    applyStimulus(1, 32'h700, 32'hA5A5A5A5, 4'b1100, 2, 1);
    applyStimulus(0, 32'h700, 0, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 2), a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Abort a fill with reset, then the earlier line must miss again.
    applyStimulus(0, 32'h100, 0, 0, 0, 0);
    @(negedge clk);
    i_addr = 32'h500; i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    @(negedge clk);
    checkOutput("abortFillReq", mem_req, 1);
    rst_x = 1'b0;
    @(negedge clk);
    checkOutput("abortReqDrop", mem_req, 0);
    checkOutput("abortState", state, 0);
    runInit();
    applyStimulus(0, 32'h100, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
